// File: rtl/mage_pkg.sv
// Shared defaults and width helpers for the HWLP reorder pipeline and its lanes.
package mage_pkg;

  localparam int N_AGE_D    = 8;
  localparam int RF_DEPTH_D = 8;
  localparam int N_LP_D     = 3;
  localparam int N_IVS_D    = 4;
  localparam int NBIT_IV_D  = 16;
  localparam int CNT_W_D    = 16;

  // An IV-constraint select equal to the loop count means "unconstrained".
  localparam int CSTR_NONE_D = N_LP_D;

  // Width of an RF-entry index; never below one bit so ports stay legal.
  function automatic int sel_w(input int rf_depth);
    return (rf_depth > 1) ? $clog2(rf_depth) : 1;
  endfunction

  // Width of an IV-constraint select (0..N_LP inclusive).
  function automatic int csel_w(input int n_lp);
    return (n_lp > 0) ? $clog2(n_lp + 1) : 1;
  endfunction

endpackage

// File: rtl/hwlp_rou_pipe_if.sv
// Bus bundle between the HWLP register file / kernel control and the reorder pipeline.
interface hwlp_rou_pipe_if
  import mage_pkg::*;
#(
    parameter int N_AGE    = N_AGE_D,
    parameter int RF_DEPTH = RF_DEPTH_D,
    parameter int N_LP     = N_LP_D,
    parameter int N_IVS    = N_IVS_D,
    parameter int NBIT_IV  = NBIT_IV_D,
    parameter int CNT_W    = CNT_W_D
);
    localparam int SEL_W  = sel_w(RF_DEPTH);
    localparam int CSEL_W = csel_w(N_LP);

    // There is no per-AGE ready: stream_valid_o qualifies a beat, and the only
    // back-pressure is the global stall_i, which freezes every output and counter.
    logic                                          clear_i;
    logic                                          stall_i;
    logic [N_AGE-1:0]                              age_active_i;
    logic [N_AGE-1:0][SEL_W-1:0]                   hwlp_sel_i;
    logic [RF_DEPTH-1:0][N_LP-1:0][NBIT_IV-1:0]    hwlp_rf_i;
    logic [RF_DEPTH-1:0]                           hwlp_valid_i;
    logic [RF_DEPTH-1:0]                           end_lp_i;
    logic [RF_DEPTH-1:0][N_LP-1:0]                 hwlp_end_cond_i;
    logic [N_AGE-1:0][CSEL_W-1:0]                  iv_cstr_sel_i;
    logic [N_AGE-1:0][NBIT_IV-1:0]                 iv_cstr_val_i;
    logic [N_AGE-1:0]                              acc_store_i;
    logic [N_AGE-1:0][SEL_W-1:0]                   acc_lag_i;

    logic [N_AGE-1:0]                              stream_valid_o;
    logic [N_AGE-1:0]                              end_lp_o;
    logic [N_AGE-1:0]                              pea_acc_reset_o;
    logic [N_AGE-1:0][N_IVS-1:0][NBIT_IV-1:0]      hwlp_rou_o;
    logic [N_AGE-1:0][CNT_W-1:0]                   valid_cnt_o;

    modport master (
        output clear_i, stall_i, age_active_i, hwlp_sel_i, hwlp_rf_i, hwlp_valid_i,
               end_lp_i, hwlp_end_cond_i, iv_cstr_sel_i, iv_cstr_val_i, acc_store_i,
               acc_lag_i,
        input  stream_valid_o, end_lp_o, pea_acc_reset_o, hwlp_rou_o, valid_cnt_o
    );

    modport slave (
        input  clear_i, stall_i, age_active_i, hwlp_sel_i, hwlp_rf_i, hwlp_valid_i,
               end_lp_i, hwlp_end_cond_i, iv_cstr_sel_i, iv_cstr_val_i, acc_store_i,
               acc_lag_i,
        output stream_valid_o, end_lp_o, pea_acc_reset_o, hwlp_rou_o, valid_cnt_o
    );

endinterface

// File: rtl/hwlp_rou_lane.sv
// One AGE lane: entry selection, IV constraint, accumulation-reset derivation,
// plus the lane's accumulation-init flag and saturating valid-beat counter.
module hwlp_rou_lane
  import mage_pkg::*;
#(
    parameter int RF_DEPTH = RF_DEPTH_D,
    parameter int N_LP     = N_LP_D,
    parameter int N_IVS    = N_IVS_D,
    parameter int NBIT_IV  = NBIT_IV_D,
    parameter int CNT_W    = CNT_W_D,
    localparam int SEL_W   = sel_w(RF_DEPTH),
    localparam int CSEL_W  = csel_w(N_LP)
) (
    input  logic                                       clk_i,
    input  logic                                       rst_n_i,
    input  logic                                       i_clear,
    input  logic                                       i_load,
    input  logic                                       i_active,
    input  logic [SEL_W-1:0]                           i_sel,
    input  logic [RF_DEPTH-1:0][N_LP-1:0][NBIT_IV-1:0] i_rf,
    input  logic [RF_DEPTH-1:0]                        i_valid,
    input  logic [RF_DEPTH-1:0]                        i_end_lp,
    input  logic [RF_DEPTH-1:0][N_LP-1:0]              i_end_cond,
    input  logic [CSEL_W-1:0]                          i_cstr_sel,
    input  logic [NBIT_IV-1:0]                         i_cstr_val,
    input  logic                                       i_acc_store,
    input  logic [SEL_W-1:0]                           i_acc_lag,
    output logic                                       o_sv,
    output logic                                       o_end,
    output logic                                       o_ar,
    output logic [N_IVS-1:0][NBIT_IV-1:0]              o_ivs,
    output logic [CNT_W-1:0]                           o_cnt
);
    logic [SEL_W-1:0]            w_p;
    logic [N_LP:0][NBIT_IV-1:0]  w_ext;
    logic [N_LP-1:0]             w_mask;
    logic                        w_constrained;
    logic                        w_hit;
    logic                        w_lo_zero;
    logic                        w_lag_zero;
    logic                        w_cv;
    logic                        w_ar_raw;

    logic                        r_init_done;
    logic [CNT_W-1:0]            r_cnt;

    always_comb begin
        // Modular subtraction in SEL_W bits gives the wrap-around lag entry.
        w_p           = i_sel - i_acc_lag;
        w_ext         = '0;
        w_mask        = '0;
        w_hit         = 1'b0;
        w_lo_zero     = 1'b1;
        w_lag_zero    = 1'b0;
        w_constrained = (i_cstr_sel < CSEL_W'(N_LP));
        for (int j = 0; j < N_LP; j++) begin
            w_ext[j] = i_rf[i_sel][j];
            if (CSEL_W'(j) < i_cstr_sel) begin
                w_mask[j] = 1'b1;
                if (i_rf[i_sel][j] != '0) w_lo_zero = 1'b0;
            end
            if (CSEL_W'(j) == i_cstr_sel) begin
                w_hit      = (i_rf[i_sel][j] == i_cstr_val);
                w_lag_zero = (i_rf[w_p][j] == '0);
            end
        end
        w_cv = w_constrained ? (w_hit & w_lo_zero) : 1'b1;

        if (!i_acc_store) begin
            w_ar_raw = 1'b0;
        end else if (!r_init_done) begin
            w_ar_raw = i_valid[w_p];
        end else begin
            w_ar_raw = w_constrained & w_lag_zero & ((i_end_cond[w_p] & w_mask) == w_mask);
        end

        o_sv  = i_active & i_valid[i_sel] & w_cv;
        o_end = i_active & i_end_lp[i_sel];
        o_ar  = i_active & w_ar_raw;
        o_ivs = '0;
        for (int j = 0; j < N_IVS; j++) begin
            o_ivs[j] = i_active ? w_ext[j] : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_init_done <= 1'b0;
            r_cnt       <= '0;
        end else if (i_clear) begin
            r_init_done <= 1'b0;
            r_cnt       <= '0;
        end else if (i_load) begin
            if (o_ar) r_init_done <= 1'b1;
            if (o_sv && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hwlp_rou_pipe.sv
// Pipelined HWLP reorder unit: N_AGE lanes feeding one registered output stage
// with global stall and synchronous clear (clear wins over stall).
module hwlp_rou_pipe
  import mage_pkg::*;
#(
    parameter int N_AGE    = N_AGE_D,
    parameter int RF_DEPTH = RF_DEPTH_D,
    parameter int N_LP     = N_LP_D,
    parameter int N_IVS    = N_IVS_D,
    parameter int NBIT_IV  = NBIT_IV_D,
    parameter int CNT_W    = CNT_W_D
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    hwlp_rou_pipe_if.slave bus
);
    logic                                     w_load;
    logic [N_AGE-1:0]                         w_sv;
    logic [N_AGE-1:0]                         w_end;
    logic [N_AGE-1:0]                         w_ar;
    logic [N_AGE-1:0][N_IVS-1:0][NBIT_IV-1:0] w_ivs;
    logic [N_AGE-1:0][CNT_W-1:0]              w_cnt;

    logic [N_AGE-1:0]                         r_sv;
    logic [N_AGE-1:0]                         r_end;
    logic [N_AGE-1:0]                         r_ar;
    logic [N_AGE-1:0][N_IVS-1:0][NBIT_IV-1:0] r_ivs;

    assign w_load = ~bus.stall_i & ~bus.clear_i;

    for (genvar g = 0; g < N_AGE; g++) begin : g_lane
        hwlp_rou_lane #(
            .RF_DEPTH (RF_DEPTH),
            .N_LP     (N_LP),
            .N_IVS    (N_IVS),
            .NBIT_IV  (NBIT_IV),
            .CNT_W    (CNT_W)
        ) u_lane (
            .clk_i       (clk_i),
            .rst_n_i     (rst_n_i),
            .i_clear     (bus.clear_i),
            .i_load      (w_load),
            .i_active    (bus.age_active_i[g]),
            .i_sel       (bus.hwlp_sel_i[g]),
            .i_rf        (bus.hwlp_rf_i),
            .i_valid     (bus.hwlp_valid_i),
            .i_end_lp    (bus.end_lp_i),
            .i_end_cond  (bus.hwlp_end_cond_i),
            .i_cstr_sel  (bus.iv_cstr_sel_i[g]),
            .i_cstr_val  (bus.iv_cstr_val_i[g]),
            .i_acc_store (bus.acc_store_i[g]),
            .i_acc_lag   (bus.acc_lag_i[g]),
            .o_sv        (w_sv[g]),
            .o_end       (w_end[g]),
            .o_ar        (w_ar[g]),
            .o_ivs       (w_ivs[g]),
            .o_cnt       (w_cnt[g])
        );
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sv  <= '0;
            r_end <= '0;
            r_ar  <= '0;
            r_ivs <= '0;
        end else if (bus.clear_i) begin
            r_sv  <= '0;
            r_end <= '0;
            r_ar  <= '0;
            r_ivs <= '0;
        end else if (!bus.stall_i) begin
            r_sv  <= w_sv;
            r_end <= w_end;
            r_ar  <= w_ar;
            r_ivs <= w_ivs;
        end
    end

    assign bus.stream_valid_o  = r_sv;
    assign bus.end_lp_o        = r_end;
    assign bus.pea_acc_reset_o = r_ar;
    assign bus.hwlp_rou_o      = r_ivs;
    assign bus.valid_cnt_o     = w_cnt;

endmodule

// File: doc/hwlp_rou_pipe.md
# hwlp_rou_pipe

Parametrised, pipelined successor of the HWLP reorder unit. It sits between the HWLP register file and the address-generation engines (AGEs). For each AGE it selects the loop-variable entry, applies the IV constraint, and derives the end and accumulation-reset signals. All outputs are registered, with a global stall. Unlike the previous generation, it adds:
- a per-AGE programmable accumulation lag, replacing the fixed mode table;
- per-AGE accumulation-init tracking;
- per-AGE valid-beat counters.

## Interface
Parameters:
- N_AGE, 8, number of AGEs served
- RF_DEPTH, 8, HWLP RF entries (power of two)
- N_LP, 3, loop variables per RF entry
- N_IVS, 4, IVs presented per AGE (≤ N_LP+1); IV index ≥ N_LP reads 0
- NBIT_IV, 16, IV width
- CNT_W, 16, valid-beat counter width

Derived widths:
- SEL_W = $clog2(RF_DEPTH)
- CSEL_W = $clog2(N_LP+1)

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous clear of all state (pulse at kernel start)
- stall_i  in  1  hold all registers
- age_active_i  in  N_AGE  AGE enabled
- hwlp_sel_i  in  N_AGE×SEL_W  RF entry used by each AGE
- hwlp_rf_i  in  RF_DEPTH×N_LP×NBIT_IV  RF loop variables
- hwlp_valid_i  in  RF_DEPTH  RF entry valid
- end_lp_i  in  RF_DEPTH  RF entry end-of-loop
- hwlp_end_cond_i  in  RF_DEPTH×N_LP  per-LP restart flags
- iv_cstr_sel_i  in  N_AGE×CSEL_W  constrained IV index; value N_LP means unconstrained
- iv_cstr_val_i  in  N_AGE×NBIT_IV  constraint value
- acc_store_i  in  N_AGE  AGE performs an accumulation store
- acc_lag_i  in  N_AGE×SEL_W  RF-entry distance to the accumulation producer
- stream_valid_o  out  N_AGE  AGE beat valid
- end_lp_o  out  N_AGE  reordered end signal
- pea_acc_reset_o  out  N_AGE  PE accumulator reset
- hwlp_rou_o  out  N_AGE×N_IVS×NBIT_IV  reordered IVs
- valid_cnt_o  out  N_AGE×CNT_W  emitted valid beats

## Operation
Per AGE i, combinational stage. Notation: s = hwlp_sel_i[i], c = iv_cstr_sel_i[i], lag entry p = (s − acc_lag_i[i]) mod RF_DEPTH, with wrap-around.
- IVs: ivs[j] = hwlp_rf_i[s][j] for j < N_LP, else 0.
- Mask: mask = (1<<c) − 1, which selects the IVs below c.
- Constraint:
  - If c == N_LP: cv = 1.
  - Otherwise: cv = (ivs[c] == iv_cstr_val_i[i]) AND every IV under mask is zero.
  - c > N_LP is treated as unconstrained.
- Stream valid: sv = hwlp_valid_i[s] & cv.
- Accumulation reset, only when acc_store_i[i] = 1; otherwise ar = 0:
  - If init_done[i] = 0: ar = hwlp_valid_i[p].
  - If init_done[i] = 1: ar = (c < N_LP) AND (hwlp_rf_i[p][c] == 0) AND ((hwlp_end_cond_i[p] & mask) == mask). The mask comparison is bitwise.
- Inactive AGE (age_active_i[i] = 0): sv, end, ar and ivs are all forced to 0.

Register stage: when stall_i = 0 and clear_i = 0, the output registers load sv, end_lp_i[s] (gated by active), ar and ivs.

State updates, on a loading cycle only:
- init_done[i] is set when ar = 1 loads. It is never cleared except by clear_i or reset.
- valid_cnt[i] increments when sv = 1 loads. It saturates at 2^CNT_W − 1.

## Timing
- Latency: 1 cycle from inputs to outputs. No combinational input→output path.
- Reset values: every output 0; init_done 0; counters 0.
- clear_i has priority over stall_i. On the next edge, outputs, init_done and counters all go to 0.
- stall_i = 1: outputs, init_done and counters hold. Inputs during a stall are discarded.
- acc_lag_i = 0: the lag entry is the AGE's own entry.
- Lag wrap: s = 1, lag = 3, RF_DEPTH = 8 gives p = 6.
- Asynchronous reset mid-kernel: all state drops to 0 immediately. The first accumulation after reset again uses the init path.
- init_done is per AGE. One AGE's reset does not switch other AGEs to the constraint path.

## Structure
Shared package (mage_pkg):
- default parameter values;
- SEL_W and CSEL_W helper functions;
- the unconstrained-select encoding constant.

Sub-module hwlp_rou_lane holds one AGE's combinational selection/constraint logic plus its init_done and valid_cnt registers. The top level generates N_AGE lanes and owns the shared output register and stall/clear gating.

## Test plan
- Unconstrained stream:
  - Stimulus: active AGE0, s = 2, c = 3, hwlp_valid_i[2] = 1, rf[2] = {5, 6, 7}.
  - Response, next cycle: stream_valid_o[0] = 1, hwlp_rou_o[0] = {5, 6, 7, 0}, valid_cnt_o[0] = 1.
- Constrained stream:
  - Stimulus: c = 1, value 4; rf = {0, 4, 9} → valid = 1. Then rf = {1, 4, 9}.
  - Response: valid = 0 (a lower IV is non-zero).
- Accumulation init then steady state:
  - Stimulus: acc_store_i = 1, s = 5, lag = 2, hwlp_valid_i[3] = 1. Then rf[3][c] = 0 with end_cond[3] = 3'b011 and c = 2.
  - Response: pea_acc_reset_o pulses from the init path, then again from the constraint path.
  - Check: with end_cond = 3'b001, no reset.
- Lag wrap-around: s = 1, lag = 3 → reset follows hwlp_valid_i[6].
- Stall/clear:
  - stall_i = 1 for 3 cycles → outputs and counters frozen.
  - clear_i = 1 with stall_i = 1 → everything returns to 0.
  - Counter at 0xFFFF stays at 0xFFFF.
- Inactive AGE and asynchronous reset:
  - Inactive AGE3 with a valid entry → all AGE3 outputs 0.
  - Asserting rst_n_i low mid-run zeroes outputs without waiting for a clock edge.
